// File: rtl/dino_game_engine.sv
// Per-frame game logic for the dino runner: jump/duck physics, cactus scroll,
// collision and score, presented to the display bridge with a pos_valid strobe.
module dino_game_engine #(
  parameter int GROUND_Y    = 200,
  parameter int DINO_X      = 40,
  parameter int SPRITE      = 32,
  parameter int CAC_START_X = 240,
  parameter int CAC_SPEED   = 4,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic        restart,
  output logic [7:0]  dino_y,
  output logic [7:0]  cac_x,
  output logic [1:0]  pose,
  output logic [15:0] score,
  output logic        game_over,
  output logic        pos_valid
);

  typedef enum logic [1:0] {RUN = 2'd0, JUMP = 2'd1, DUCK = 2'd2, DEAD = 2'd3} state_t;

  localparam logic [7:0] GROUND_Y8 = 8'(GROUND_Y);
  localparam logic [7:0] CAC_START8 = 8'(CAC_START_X);
  localparam logic [7:0] CAC_SPEED8 = 8'(CAC_SPEED);
  localparam logic [7:0] JUMP_V08 = 8'(JUMP_V0);
  localparam logic [7:0] GRAVITY8 = 8'(GRAVITY);

  state_t             state_q, state_d;
  logic [7:0]         height_q, height_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [7:0]         dino_y_q, dino_y_d;
  logic [7:0]         cac_x_q, cac_x_d;
  logic [15:0]        score_q, score_d;
  logic               game_over_q, game_over_d;
  logic               pos_valid_q, pos_valid_d;
  logic               chk_q, chk_d;
  logic signed [9:0]  h_sum;
  logic               hit;

  assign h_sum = $signed({2'b00, height_q}) + $signed({{2{vel_q[7]}}, vel_q});

  assign hit = (({1'b0, cac_x_q} + 9'(SPRITE)) > 9'(DINO_X)) &&
               ({1'b0, cac_x_q} < 9'(DINO_X + SPRITE)) &&
               (height_q < 8'(SPRITE));

  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    vel_d       = vel_q;
    dino_y_d    = dino_y_q;
    cac_x_d     = cac_x_q;
    score_d     = score_q;
    pos_valid_d = 1'b0;
    chk_d       = 1'b0;

    if (frame_tick) begin
      if (state_q == DEAD) begin
        if (restart) begin
          state_d     = RUN;
          height_d    = 8'd0;
          vel_d       = 8'sd0;
          dino_y_d    = GROUND_Y8;
          cac_x_d     = CAC_START8;
          score_d     = 16'd0;
          pos_valid_d = 1'b1;
        end
      end else begin
        pos_valid_d = 1'b1;
        chk_d       = 1'b1;
        case (state_q)
          RUN, DUCK: begin
            if (btn_jump) begin
              state_d  = JUMP;
              height_d = JUMP_V08;
              vel_d    = $signed(JUMP_V08 - GRAVITY8);
            end else if (btn_duck) begin
              state_d = DUCK;
            end else begin
              state_d = RUN;
            end
          end
          JUMP: begin
            if (h_sum <= 10'sd0) begin
              state_d  = RUN;
              height_d = 8'd0;
              vel_d    = 8'sd0;
            end else begin
              height_d = h_sum[7:0];
              vel_d    = $signed(vel_q - GRAVITY8);
            end
          end
          default: state_d = state_q;
        endcase

        if (cac_x_q < CAC_SPEED8) begin
          cac_x_d = CAC_START8;
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
        end else begin
          cac_x_d = cac_x_q - CAC_SPEED8;
        end
        dino_y_d = GROUND_Y8 - height_d;
      end
    end

    // A hit from the previous tick wins over any state change from a back-to-back tick.
    if (chk_q && hit && state_q != DEAD) begin
      state_d = DEAD;
    end

    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      height_q    <= 8'd0;
      vel_q       <= 8'sd0;
      dino_y_q    <= GROUND_Y8;
      cac_x_q     <= CAC_START8;
      score_q     <= 16'd0;
      game_over_q <= 1'b0;
      pos_valid_q <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      vel_q       <= vel_d;
      dino_y_q    <= dino_y_d;
      cac_x_q     <= cac_x_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      pos_valid_q <= pos_valid_d;
      chk_q       <= chk_d;
    end
  end

  assign dino_y    = dino_y_q;
  assign cac_x     = cac_x_q;
  assign pose      = state_q;
  assign score     = score_q;
  assign game_over = game_over_q;
  assign pos_valid = pos_valid_q;

endmodule

// File: tb/tb_dino_game_engine.sv
// Scoreboard bench for dino_game_engine: each tick pushes the expected frame,
// and a monitor compares it whenever pos_valid strobes.
module tb_dino_game_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_jump = 1'b0;
  logic        btn_duck = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  dino_y;
  logic [7:0]  cac_x;
  logic [1:0]  pose;
  logic [15:0] score;
  logic        game_over;
  logic        pos_valid;

  typedef struct packed {
    logic [7:0]  y;
    logic [7:0]  x;
    logic [1:0]  pose;
    logic [15:0] score;
  } frame_t;

  frame_t sb[$];
  int nChecks = 0;
  int nErrors = 0;

  // Height after each tick of a jump started from the ground.
  logic [7:0] jumpHeight [25] = '{8'd12, 8'd23, 8'd33, 8'd42, 8'd50, 8'd57, 8'd63, 8'd68,
                                  8'd72, 8'd75, 8'd77, 8'd78, 8'd78, 8'd77, 8'd75, 8'd72,
                                  8'd68, 8'd63, 8'd57, 8'd50, 8'd42, 8'd33, 8'd23, 8'd12, 8'd0};

  dino_game_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_jump(btn_jump),
    .btn_duck(btn_duck), .restart(restart), .dino_y(dino_y), .cac_x(cac_x),
    .pose(pose), .score(score), .game_over(game_over), .pos_valid(pos_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic jump, input logic duck, input logic rst_req,
                               input logic expectPulse, input logic [7:0] ey,
                               input logic [7:0] ex, input logic [1:0] ep,
                               input logic [15:0] es);
    frame_t f;
    @(negedge clk);
    btn_jump   = jump;
    btn_duck   = duck;
    restart    = rst_req;
    frame_tick = 1'b1;
    if (expectPulse) begin
      f.y = ey; f.x = ex; f.pose = ep; f.score = es;
      sb.push_back(f);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    btn_jump   = 1'b0;
    btn_duck   = 1'b0;
    restart    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (pos_valid) begin
      if (sb.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL unexpected_pos_valid: got pulse with dino_y=%0d cac_x=%0d, expected none",
                 dino_y, cac_x);
      end else begin
        frame_t e;
        e = sb.pop_front();
        checkOutput("pulse_dino_y", 32'(dino_y), 32'(e.y));
        checkOutput("pulse_cac_x", 32'(cac_x), 32'(e.x));
        checkOutput("pulse_pose", 32'(pose), 32'(e.pose));
        checkOutput("pulse_score", 32'(score), 32'(e.score));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ey, ex;
    logic [1:0] ep;
    logic [15:0] es;

    repeat (3) @(negedge clk);
    checkOutput("reset_dino_y", 32'(dino_y), 32'd200);
    checkOutput("reset_cac_x", 32'(cac_x), 32'd240);
    checkOutput("reset_pose", 32'(pose), 32'd0);
    checkOutput("reset_score", 32'(score), 32'd0);
    checkOutput("reset_game_over", 32'(game_over), 32'd0);
    checkOutput("reset_pos_valid", 32'(pos_valid), 32'd0);
    reset = 1'b0;

    // Run straight into the first cactus: tick 43 lands on x=68 and dies.
    for (int k = 1; k <= 43; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 8'(240 - 4 * k), 2'd0, 16'd0);
    end
    checkOutput("dead_pose", 32'(pose), 32'd3);
    checkOutput("dead_game_over", 32'(game_over), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 16'd0);
    checkOutput("dead_frozen_cac_x", 32'(cac_x), 32'd68);
    checkOutput("dead_frozen_pose", 32'(pose), 32'd3);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 8'd240, 2'd0, 16'd0);
    checkOutput("restart_game_over", 32'(game_over), 32'd0);
    checkOutput("restart_pose", 32'(pose), 32'd0);

    // Jump with btn_jump held through tick 24; buttons are ignored while airborne.
    for (int k = 1; k <= 25; k++) begin
      ey = 8'(200 - int'(jumpHeight[k - 1]));
      ep = (k <= 24) ? 2'd1 : 2'd0;
      applyStimulus((k <= 24), 1'b0, 1'b0, 1'b1, ey, 8'(240 - 4 * k), ep, 16'd0);
    end

    for (int k = 26; k <= 31; k++) begin
      ep = (k <= 30) ? 2'd2 : 2'd0;
      applyStimulus(1'b0, (k <= 30), 1'b0, 1'b1, 8'd200, 8'(240 - 4 * k), ep, 16'd0);
    end

    // Jump at tick 40 clears the cactus; wrap to 240 at tick 61 scores one.
    for (int k = 32; k <= 64; k++) begin
      ey = (k >= 40) ? 8'(200 - int'(jumpHeight[k - 40])) : 8'd200;
      ep = (k >= 40 && k <= 63) ? 2'd1 : 2'd0;
      ex = (k <= 60) ? 8'(240 - 4 * k) : 8'(240 - 4 * (k - 61));
      es = (k >= 61) ? 16'd1 : 16'd0;
      applyStimulus((k == 40), 1'b0, 1'b0, 1'b1, ey, ex, ep, es);
    end
    checkOutput("survive_game_over", 32'(game_over), 32'd0);
    checkOutput("survive_score", 32'(score), 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd188, 8'd224, 2'd1, 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd177, 8'd220, 2'd1, 16'd1);

    // Async reset right after a tick edge cancels its pending strobe.
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_dino_y", 32'(dino_y), 32'd200);
    checkOutput("async_pose", 32'(pose), 32'd0);
    checkOutput("async_cac_x", 32'(cac_x), 32'd240);
    checkOutput("async_score", 32'(score), 32'd0);
    checkOutput("async_pos_valid", 32'(pos_valid), 32'd0);
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 8'd236, 2'd0, 16'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
